// File: rtl/encoder_move_ctrl_if.sv
// Command/status bundle between the navigation FSM (master) and encoder_move_ctrl (slave).
interface encoder_move_ctrl_if #(
  parameter int unsigned CNT_W = 10
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] target;
  logic             abort;
  logic [3:0]       in_drv;
  logic             en_a;
  logic             en_b;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             fault;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output start, mode, target, abort,
    input  in_drv, en_a, en_b, busy, done, aborted, fault, cnt_a, cnt_b
  );

  modport slave (
    input  start, mode, target, abort,
    output in_drv, en_a, en_b, busy, done, aborted, fault, cnt_a, cnt_b
  );
endinterface

// File: rtl/encoder_move_ctrl.sv
// Closed-loop two-wheel move sequencer with encoder tick counting and skew gating.
// Optional stall watchdog enabled by defining ENC_WATCHDOG_EN.
module encoder_move_ctrl #(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned SYNC_N   = 2,
  parameter int unsigned SKEW_MAX = 2,
  parameter int unsigned WD_W     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enc_a,
  input  logic                enc_b,
  encoder_move_ctrl_if.slave  bus
);

  localparam int unsigned EW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SYNC_N-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic              prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        in_drv_q, in_drv_d;
  logic              en_a_q, en_a_d, en_b_q, en_b_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              aborted_q, aborted_d, fault_q, fault_d;

  logic              edge_a_c, edge_b_c;
  logic [EW-1:0]     a_x, b_x, t_x;
  logic              a_reached, b_reached, a_lead, b_lead;

`ifdef ENC_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_MAX = '1;
  logic [WD_W-1:0]   wd_q, wd_d;
`else
  logic              unused_wd;
  assign unused_wd = (WD_W == 0);
`endif

  // Synchroniser chains feed a rising-edge detector on the last stage.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_N-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_N-2:0], enc_b};
    prev_a_d = sync_a_q[SYNC_N-1];
    prev_b_d = sync_b_q[SYNC_N-1];
    edge_a_c = sync_a_q[SYNC_N-1] & ~prev_a_q;
    edge_b_c = sync_b_q[SYNC_N-1] & ~prev_b_q;
  end

  // Extended-width compares so cnt + SKEW_MAX never wraps.
  always_comb begin
    a_x       = EW'(cnt_a_q);
    b_x       = EW'(cnt_b_q);
    t_x       = EW'(target_q);
    a_reached = (a_x >= t_x);
    b_reached = (b_x >= t_x);
    a_lead    = (a_x > (b_x + EW'(SKEW_MAX)));
    b_lead    = (b_x > (a_x + EW'(SKEW_MAX)));
  end

  // Next state, latched command, counters and completion flags.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    aborted_d = aborted_q;
    fault_d   = fault_q;
`ifdef ENC_WATCHDOG_EN
    wd_d      = '0;
`endif

    if (state_q == S_RUN) begin
      if (edge_a_c && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (edge_b_c && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
`ifdef ENC_WATCHDOG_EN
      if (edge_a_c || edge_b_c) wd_d = '0;
      else if (wd_q != WD_MAX)  wd_d = wd_q + WD_W'(1);
      else                      wd_d = wd_q;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          target_d  = bus.target;
          cnt_a_d   = '0;
          cnt_b_d   = '0;
          aborted_d = 1'b0;
          fault_d   = 1'b0;
          state_d   = (bus.target == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end
`ifdef ENC_WATCHDOG_EN
        else if (wd_q == WD_MAX) begin
          aborted_d = 1'b1;
          fault_d   = 1'b1;
          state_d   = S_DONE;
        end
`endif
        else if (a_reached && b_reached) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drive outputs follow the registered state by one cycle.
  always_comb begin
    in_drv_d = 4'b0000;
    en_a_d   = 1'b0;
    en_b_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = (state_q == S_DONE);
    if (state_q == S_RUN) begin
      busy_d = 1'b1;
      en_a_d = ~a_reached & ~a_lead;
      en_b_d = ~b_reached & ~b_lead;
      case (mode_q)
        2'b00: in_drv_d = 4'b1001;
        2'b01: in_drv_d = 4'b0101;
        2'b10: in_drv_d = 4'b1010;
        2'b11: in_drv_d = 4'b0110;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      prev_a_q  <= 1'b0;
      prev_b_q  <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      target_q  <= '0;
      mode_q    <= 2'b00;
      in_drv_q  <= 4'b0000;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      fault_q   <= 1'b0;
`ifdef ENC_WATCHDOG_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      prev_a_q  <= prev_a_d;
      prev_b_q  <= prev_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      target_q  <= target_d;
      mode_q    <= mode_d;
      in_drv_q  <= in_drv_d;
      en_a_q    <= en_a_d;
      en_b_q    <= en_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      fault_q   <= fault_d;
`ifdef ENC_WATCHDOG_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign bus.in_drv  = in_drv_q;
  assign bus.en_a    = en_a_q;
  assign bus.en_b    = en_b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.fault   = fault_q;
  assign bus.cnt_a   = cnt_a_q;
  assign bus.cnt_b   = cnt_b_q;

endmodule
